// File: rtl/nios2_design_ram_arbiter.sv
// nios2_design_ram_arbiter: two-master Avalon-MM arbiter sharing port s1 of the
// 256x32 MMU RAM. At most one transfer per cycle is issued to the RAM.
// The loser is stalled with waitrequest. Read data returns one cycle after accept.
// Configuration macro NIOS2_RAM_ARB_FIXED_PRIO_EN: when defined, m0 always wins
// contention. The default build (macro undefined) uses round-robin.
module nios2_design_ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  // master 0
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  // master 1
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  // RAM port s1
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  logic m0_req;
  logic m1_req;
  logic grant_m0;
  logic grant_m1;
  logic grant_any;
  logic grant_write;

  logic rd_pend_q, rd_pend_d;
  logic rd_src_q,  rd_src_d;

  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [BE_W-1:0]   be_q,    be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

`ifndef NIOS2_RAM_ARB_FIXED_PRIO_EN
  typedef enum logic {
    LAST_M0 = 1'b0,
    LAST_M1 = 1'b1
  } last_grant_e;

  last_grant_e last_grant_q, last_grant_d;
`endif

  // a simultaneous read+write counts as one request (treated as a write)
  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;

  // arbitration: single requester wins; contention resolved by priority scheme
  always_comb begin
    grant_m0 = 1'b0;
    grant_m1 = 1'b0;
    if (!reset) begin
      if (m0_req && m1_req) begin
`ifdef NIOS2_RAM_ARB_FIXED_PRIO_EN
        grant_m0 = 1'b1;
`else
        if (last_grant_q == LAST_M1) begin
          grant_m0 = 1'b1;
        end else begin
          grant_m1 = 1'b1;
        end
`endif
      end else begin
        grant_m0 = m0_req;
        grant_m1 = m1_req;
      end
    end
  end

  assign grant_any = grant_m0 | grant_m1;

  // waitrequest is forced high during reset, otherwise only the losing requester stalls
  always_comb begin
    m0_waitrequest = reset | (m0_req & ~grant_m0);
    m1_waitrequest = reset | (m1_req & ~grant_m1);
  end

  // RAM request mux; without a grant the address/data buses keep their last values
  always_comb begin
    ram_address    = addr_q;
    ram_byteenable = be_q;
    ram_writedata  = wdata_q;
    grant_write    = 1'b0;
    if (grant_m1) begin
      ram_address    = m1_address;
      ram_byteenable = m1_byteenable;
      ram_writedata  = m1_writedata;
      grant_write    = m1_write;
    end else if (grant_m0) begin
      ram_address    = m0_address;
      ram_byteenable = m0_byteenable;
      ram_writedata  = m0_writedata;
      grant_write    = m0_write;
    end
    ram_chipselect = grant_any;
    ram_write      = grant_write;
    ram_clken      = ~reset;
  end

  // next-state for read tracking, bus hold registers and the round-robin pointer
  always_comb begin
    rd_pend_d = grant_any & ~grant_write;
    rd_src_d  = rd_src_q;
    if (grant_any && !grant_write) begin
      rd_src_d = grant_m1;
    end
    addr_d  = ram_address;
    be_d    = ram_byteenable;
    wdata_d = ram_writedata;
`ifndef NIOS2_RAM_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
    if (grant_m1) begin
      last_grant_d = LAST_M1;
    end else if (grant_m0) begin
      last_grant_d = LAST_M0;
    end
`endif
  end

  // control state: pointer and read tracking, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q <= 1'b0;
      rd_src_q  <= 1'b0;
`ifndef NIOS2_RAM_ARB_FIXED_PRIO_EN
      last_grant_q <= LAST_M1;
`endif
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_src_q  <= rd_src_d;
`ifndef NIOS2_RAM_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // datapath hold registers keep the last driven RAM bus values
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    be_q    <= be_d;
    wdata_q <= wdata_d;
  end

  // read response: valid gated by reset so a pending read is dropped when reset hits
  always_comb begin
    m0_readdatavalid = rd_pend_q & ~rd_src_q & ~reset;
    m1_readdatavalid = rd_pend_q &  rd_src_q & ~reset;
    m0_readdata      = ram_readdata;
    m1_readdata      = ram_readdata;
  end

endmodule

// File: tb/tb_nios2_design_ram_arbiter.sv
// Testbench for nios2_design_ram_arbiter with an attached RAM model and a
// transaction-level reference model (grant rule, shadow memory, response slot).
module tb_nios2_design_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  m0_address = '0, m1_address = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [7:0]  ram_address;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_writedata;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_readdata;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  nios2_design_ram_arbiter #(.ADDR_W(8), .DATA_W(32), .BE_W(4)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_writedata(ram_writedata), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
  );

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // RAM model: registered q, byte-lane writes
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) mem[ram_address] <= merge(mem[ram_address], ram_writedata, ram_byteenable);
      ram_readdata <= mem[ram_address];
    end
  end

  // ---------------- reference model ----------------
  logic        m_last = 1'b1;   // 1: m1 was granted most recently
  logic        m_pend = 1'b0;
  logic        m_src  = 1'b0;
  logic [31:0] m_data = '0;
  logic [7:0]  m_haddr = '0;
  logic [3:0]  m_hbe = '0;
  logic        m_hvalid = 1'b0;
  logic [31:0] shadow [256];

  // expected {grant_m1, grant_m0}
  function automatic logic [1:0] exp_grant(input logic rst, input logic q0, input logic q1);
    if (rst) return 2'b00;
    if (q0 && q1) begin
`ifdef NIOS2_RAM_ARB_FIXED_PRIO_EN
      return 2'b01;
`else
      return m_last ? 2'b01 : 2'b10;
`endif
    end
    return {q1, q0};
  endfunction

  // advance the model across the coming clock edge using the inputs now applied
  task automatic model_step();
    logic [1:0] g;
    logic       sel, wr;
    logic [7:0] a;
    logic [3:0] be;
    logic [31:0] d;
    g = exp_grant(reset, m0_read | m0_write, m1_read | m1_write);
    if (reset) begin
      m_last = 1'b1; m_pend = 1'b0; m_src = 1'b0;
    end else begin
      m_pend = 1'b0;
      if (g != 2'b00) begin
        sel = g[1];
        wr  = sel ? m1_write : m0_write;
        a   = sel ? m1_address : m0_address;
        be  = sel ? m1_byteenable : m0_byteenable;
        d   = sel ? m1_writedata : m0_writedata;
        m_last = sel;
        m_haddr = a; m_hbe = be; m_hvalid = 1'b1;
        if (wr) shadow[a] = merge(shadow[a], d, be);
        else begin m_pend = 1'b1; m_src = sel; m_data = shadow[a]; end
      end
    end
  endtask

  // apply one cycle of stimulus at the falling edge, then settle
  task automatic put(input logic rst,
                     input logic r0, input logic w0, input logic [7:0] a0,
                     input logic [3:0] be0, input logic [31:0] d0,
                     input logic r1, input logic w1, input logic [7:0] a1,
                     input logic [3:0] be1, input logic [31:0] d1);
    @(negedge clk);
    reset = rst;
    m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = d0;
    m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
    #2;
  endtask

  task automatic idle(input logic rst);
    put(rst, 0, 0, 8'h00, 4'h0, '0, 0, 0, 8'h00, 4'h0, '0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      put(1, 1, 0, 8'h01, 4'hF, '0, 1, 1, 8'h02, 4'hF, 32'h5);
      total++; if (m0_waitrequest !== 1'b1) begin bad++; $display("FAIL rst_wait0 got=%b exp=1", m0_waitrequest); end
      total++; if (m1_waitrequest !== 1'b1) begin bad++; $display("FAIL rst_wait1 got=%b exp=1", m1_waitrequest); end
      total++; if (ram_chipselect !== 1'b0) begin bad++; $display("FAIL rst_cs got=%b exp=0", ram_chipselect); end
      total++; if (ram_write !== 1'b0) begin bad++; $display("FAIL rst_write got=%b exp=0", ram_write); end
      total++; if ({m1_readdatavalid, m0_readdatavalid} !== 2'b00) begin bad++; $display("FAIL rst_rdv got=%b exp=00", {m1_readdatavalid, m0_readdatavalid}); end
      total++; if (ram_clken !== 1'b0) begin bad++; $display("FAIL rst_clken got=%b exp=0", ram_clken); end
      model_step();
    end
    idle(0);
    total++; if (ram_clken !== 1'b1) begin bad++; $display("FAIL clken got=%b exp=1", ram_clken); end
    model_step();
  endtask

  task automatic preload();
    logic [31:0] v;
    for (int a = 0; a < 64; a++) begin
      v = (a == 16) ? 32'hDEADBEEF : (a == 32) ? 32'h0 : $urandom;
      put(0, 0, 1, 8'(a), 4'hF, v, 0, 0, 8'h00, 4'h0, '0);
      model_step();
    end
    idle(0); model_step();
  endtask

  task automatic test_single_read();
    put(0, 1, 0, 8'h10, 4'hF, '0, 0, 0, 8'h00, 4'h0, '0);
    total++; if (m0_waitrequest !== 1'b0) begin bad++; $display("FAIL sr_wait0 got=%b exp=0", m0_waitrequest); end
    total++; if (ram_chipselect !== 1'b1) begin bad++; $display("FAIL sr_cs got=%b exp=1", ram_chipselect); end
    total++; if (ram_address !== 8'h10) begin bad++; $display("FAIL sr_addr got=%h exp=10", ram_address); end
    total++; if (ram_write !== 1'b0) begin bad++; $display("FAIL sr_write got=%b exp=0", ram_write); end
    model_step();
    idle(0);
    total++; if (m0_readdatavalid !== 1'b1) begin bad++; $display("FAIL sr_rdv0 got=%b exp=1", m0_readdatavalid); end
    total++; if (m0_readdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sr_data got=%h exp=deadbeef", m0_readdata); end
    total++; if (m1_readdatavalid !== 1'b0) begin bad++; $display("FAIL sr_rdv1 got=%b exp=0", m1_readdatavalid); end
    model_step();
    idle(0);
    total++; if (m0_readdatavalid !== 1'b0) begin bad++; $display("FAIL sr_rdv0_end got=%b exp=0", m0_readdatavalid); end
    model_step();
  endtask

  task automatic test_contention();
    idle(1); model_step();
    put(0, 0, 1, 8'h05, 4'hF, 32'h11111111, 1, 0, 8'h05, 4'hF, '0);
    total++; if (m0_waitrequest !== 1'b0) begin bad++; $display("FAIL ct_wait0 got=%b exp=0", m0_waitrequest); end
    total++; if (m1_waitrequest !== 1'b1) begin bad++; $display("FAIL ct_wait1 got=%b exp=1", m1_waitrequest); end
    total++; if (ram_write !== 1'b1) begin bad++; $display("FAIL ct_write got=%b exp=1", ram_write); end
    model_step();
    put(0, 0, 0, 8'h00, 4'h0, '0, 1, 0, 8'h05, 4'hF, '0);
    total++; if (m1_waitrequest !== 1'b0) begin bad++; $display("FAIL ct_wait1b got=%b exp=0", m1_waitrequest); end
    total++; if (ram_address !== 8'h05) begin bad++; $display("FAIL ct_addr got=%h exp=05", ram_address); end
    model_step();
    idle(0);
    total++; if (m1_readdatavalid !== 1'b1) begin bad++; $display("FAIL ct_rdv1 got=%b exp=1", m1_readdatavalid); end
    total++; if (m1_readdata !== 32'h11111111) begin bad++; $display("FAIL ct_data got=%h exp=11111111", m1_readdata); end
    total++; if (m0_readdatavalid !== 1'b0) begin bad++; $display("FAIL ct_rdv0 got=%b exp=0", m0_readdatavalid); end
    model_step();
  endtask

  task automatic test_continuous();
    int n0, n1;
    logic e0;
    n0 = 0; n1 = 0;
    idle(1); model_step();
    for (int i = 0; i < 8; i++) begin
      put(0, 1, 0, 8'h01, 4'hF, '0, 1, 0, 8'h02, 4'hF, '0);
`ifdef NIOS2_RAM_ARB_FIXED_PRIO_EN
      e0 = 1'b1;
`else
      e0 = (i % 2 == 0);
`endif
      total++; if (m0_waitrequest !== ~e0) begin bad++; $display("FAIL cc_wait0[%0d] got=%b exp=%b", i, m0_waitrequest, ~e0); end
      total++; if (m1_waitrequest !== e0) begin bad++; $display("FAIL cc_wait1[%0d] got=%b exp=%b", i, m1_waitrequest, e0); end
      if (m0_waitrequest === 1'b0) n0++;
      if (m1_waitrequest === 1'b0) n1++;
      model_step();
    end
`ifdef NIOS2_RAM_ARB_FIXED_PRIO_EN
    total++; if (n0 != 8 || n1 != 0) begin bad++; $display("FAIL cc_counts got=%0d/%0d exp=8/0", n0, n1); end
`else
    total++; if (n0 != 4 || n1 != 4) begin bad++; $display("FAIL cc_counts got=%0d/%0d exp=4/4", n0, n1); end
`endif
    idle(0); model_step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) put(0, 1, 0, 8'(i), 4'hF, '0, 0, 0, 8'h00, 4'h0, '0);
      else idle(0);
      if (i < 4) begin
        total++; if (m0_waitrequest !== 1'b0) begin bad++; $display("FAIL b2b_wait0[%0d] got=%b exp=0", i, m0_waitrequest); end
      end
      if (i > 0) begin
        total++; if (m0_readdatavalid !== 1'b1) begin bad++; $display("FAIL b2b_rdv[%0d] got=%b exp=1", i, m0_readdatavalid); end
        total++; if (m0_readdata !== shadow[i-1]) begin bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, m0_readdata, shadow[i-1]); end
      end
      model_step();
    end
  endtask

  task automatic test_byteenable();
    put(0, 0, 0, 8'h00, 4'h0, '0, 0, 1, 8'h20, 4'b0101, 32'hAABBCCDD);
    total++; if (m1_waitrequest !== 1'b0) begin bad++; $display("FAIL be_wait1 got=%b exp=0", m1_waitrequest); end
    total++; if (ram_byteenable !== 4'b0101) begin bad++; $display("FAIL be_lanes got=%b exp=0101", ram_byteenable); end
    model_step();
    put(0, 0, 0, 8'h00, 4'h0, '0, 1, 0, 8'h20, 4'hF, '0);
    model_step();
    idle(0);
    total++; if (m1_readdatavalid !== 1'b1) begin bad++; $display("FAIL be_rdv1 got=%b exp=1", m1_readdatavalid); end
    total++; if (m1_readdata !== 32'h00BB00DD) begin bad++; $display("FAIL be_data got=%h exp=00bb00dd", m1_readdata); end
    model_step();
  endtask

  task automatic test_reset_mid_read();
    put(0, 1, 0, 8'h10, 4'hF, '0, 0, 0, 8'h00, 4'h0, '0);
    total++; if (m0_waitrequest !== 1'b0) begin bad++; $display("FAIL rmr_wait0 got=%b exp=0", m0_waitrequest); end
    model_step();
    idle(1);
    total++; if (m0_readdatavalid !== 1'b0) begin bad++; $display("FAIL rmr_rdv_in_reset got=%b exp=0", m0_readdatavalid); end
    model_step();
    idle(0);
    total++; if (m0_readdatavalid !== 1'b0) begin bad++; $display("FAIL rmr_rdv_after got=%b exp=0", m0_readdatavalid); end
    model_step();
    put(0, 1, 0, 8'h03, 4'hF, '0, 1, 0, 8'h04, 4'hF, '0);
    total++; if ({m1_waitrequest, m0_waitrequest} !== 2'b10) begin bad++; $display("FAIL rmr_first_grant got=%b exp=10", {m1_waitrequest, m0_waitrequest}); end
    model_step();
    put(0, 0, 0, 8'h00, 4'h0, '0, 1, 0, 8'h04, 4'hF, '0);
    total++; if (m1_waitrequest !== 1'b0) begin bad++; $display("FAIL rmr_m1_next got=%b exp=0", m1_waitrequest); end
    model_step();
    idle(0); model_step();
  endtask

  task automatic test_random();
    logic r0, w0, r1, w1;
    logic [7:0] a0, a1;
    logic [1:0] g;
    for (int i = 0; i < 300; i++) begin
      r0 = 1'($urandom_range(0, 1)); w0 = ($urandom_range(0, 3) == 0);
      r1 = 1'($urandom_range(0, 1)); w1 = ($urandom_range(0, 3) == 0);
      a0 = 8'($urandom_range(0, 63)); a1 = 8'($urandom_range(0, 63));
      put(0, r0, w0, a0, 4'($urandom_range(0, 15)), $urandom,
             r1, w1, a1, 4'($urandom_range(0, 15)), $urandom);
      total++; if (m0_readdatavalid !== (m_pend & ~m_src)) begin bad++; $display("FAIL rnd_rdv0[%0d] got=%b exp=%b", i, m0_readdatavalid, m_pend & ~m_src); end
      total++; if (m1_readdatavalid !== (m_pend & m_src)) begin bad++; $display("FAIL rnd_rdv1[%0d] got=%b exp=%b", i, m1_readdatavalid, m_pend & m_src); end
      if (m_pend) begin
        total++; if ((m_src ? m1_readdata : m0_readdata) !== m_data) begin bad++; $display("FAIL rnd_data[%0d] got=%h exp=%h", i, m_src ? m1_readdata : m0_readdata, m_data); end
      end
      g = exp_grant(1'b0, r0 | w0, r1 | w1);
      total++; if (m0_waitrequest !== ((r0 | w0) & ~g[0])) begin bad++; $display("FAIL rnd_wait0[%0d] got=%b exp=%b", i, m0_waitrequest, (r0 | w0) & ~g[0]); end
      total++; if (m1_waitrequest !== ((r1 | w1) & ~g[1])) begin bad++; $display("FAIL rnd_wait1[%0d] got=%b exp=%b", i, m1_waitrequest, (r1 | w1) & ~g[1]); end
      total++; if (ram_chipselect !== (|g)) begin bad++; $display("FAIL rnd_cs[%0d] got=%b exp=%b", i, ram_chipselect, |g); end
      if (|g) begin
        total++; if (ram_write !== (g[1] ? w1 : w0)) begin bad++; $display("FAIL rnd_write[%0d] got=%b exp=%b", i, ram_write, g[1] ? w1 : w0); end
        total++; if (ram_address !== (g[1] ? a1 : a0)) begin bad++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", i, ram_address, g[1] ? a1 : a0); end
      end else begin
        total++; if (ram_write !== 1'b0) begin bad++; $display("FAIL rnd_write_idle[%0d] got=%b exp=0", i, ram_write); end
        if (m_hvalid) begin
          total++; if ({ram_address, ram_byteenable} !== {m_haddr, m_hbe}) begin bad++; $display("FAIL rnd_hold[%0d] got=%h exp=%h", i, {ram_address, ram_byteenable}, {m_haddr, m_hbe}); end
        end
      end
      model_step();
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_single_read();
    test_contention();
    test_continuous();
    test_back_to_back();
    test_byteenable();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
